pps_gen: RTL

Pulse-per-second transmitter on the `clk200` domain: produces a registered PPS pulse, a one-cycle tick, and a running seconds count for the board and TDC logic that consume `pps`. It is the source end of the PPS link, so the design can run from an internal PPS without an external GPS/timing source. An optional external sync input (e.g. `clockchip_sync`) re-phases the generated second.

---
 rtl/pps_pkg.sv | 19 +
 rtl/sync_edge.sv | 30 +++
 rtl/pps_gen.sv | 109 ++++++++++
 3 files changed

// File: rtl/pps_pkg.sv
// Shared definitions for the PPS transmitter: parameter defaults, FSM states
// and the phase-counter width helper.
package pps_pkg;

    localparam int unsigned PPS_PERIOD_DEFAULT = 200_000_000;  // 200 MHz clk200
    localparam int unsigned PPS_HIGH_DEFAULT   = 20_000_000;   // 10 % duty
    localparam int unsigned PPS_CNT_W_DEFAULT  = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pps_state_e;

    // Bits needed to count 0..period-1, never less than one.
    function automatic int unsigned pps_ph_width(input int unsigned period);
        return (period <= 2) ? 1 : $clog2(period);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector, for
// asynchronous board inputs. rise_o is a one-cycle strobe, three edges after capture.
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       dly_q;
    logic       rise_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbour and the pipeline shifts cleanly.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            dly_q  <= sync_q[1];
            rise_q <= sync_q[1] & ~dly_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/pps_gen.sv
// Pulse-per-second transmitter on clk200 with registered pulse, tick, seconds
// count and lock flag. Define PPS_GEN_ALIGN_EN to add the align_i re-phasing input.
module pps_gen
    import pps_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = PPS_PERIOD_DEFAULT,
    parameter int unsigned HIGH_CYCLES   = PPS_HIGH_DEFAULT,
    parameter int unsigned CNT_W         = PPS_CNT_W_DEFAULT
) (
    input  logic             clk200,
    input  logic             sys_reset_n,
    input  logic             en_i,
`ifdef PPS_GEN_ALIGN_EN
    input  logic             align_i,
`endif
    output logic             pps_o,
    output logic             pps_tick_o,
    output logic [CNT_W-1:0] sec_cnt_o,
    output logic             locked_o
);

    localparam int unsigned    PH_W    = pps_ph_width(PERIOD_CYCLES);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(HIGH_CYCLES);

    pps_state_e       state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic             pps_q, pps_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] sec_q, sec_d;
    logic             locked_q, locked_d;

    logic             align_rise;
    logic             start_pulse;
    logic [PH_W-1:0]  ph_inc;

`ifdef PPS_GEN_ALIGN_EN
    sync_edge u_align_sync (
        .clk_i   (clk200),
        .rst_ni  (sys_reset_n),
        .async_i (align_i),
        .rise_o  (align_rise)
    );
`else
    assign align_rise = 1'b0;
`endif

    // A pulse starts on enable from IDLE, on the natural wrap, or on an align
    // event; coincident causes collapse into a single start. Disable wins.
    assign start_pulse = en_i && ((state_q == ST_IDLE) || (ph_q == PH_LAST) || align_rise);
    assign ph_inc      = ph_q + PH_W'(1);

    always_ff @(posedge clk200) begin
        if (!sys_reset_n) begin
            state_q  <= ST_IDLE;
            ph_q     <= '0;
            pps_q    <= 1'b0;
            tick_q   <= 1'b0;
            sec_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            pps_q    <= pps_d;
            tick_q   <= tick_d;
            sec_q    <= sec_d;
            locked_q <= locked_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en_i)  state_d = ST_RUN;
            ST_RUN:  if (!en_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        ph_d     = '0;
        pps_d    = 1'b0;
        tick_d   = 1'b0;
        sec_d    = sec_q;
        locked_d = locked_q;

        if (start_pulse) begin
            pps_d  = 1'b1;
            tick_d = 1'b1;
            sec_d  = sec_q + CNT_W'(1);
`ifdef PPS_GEN_ALIGN_EN
            if ((state_q == ST_RUN) && align_rise) locked_d = 1'b1;
`else
            locked_d = 1'b1;
`endif
        end else if ((state_q == ST_RUN) && en_i) begin
            ph_d  = ph_inc;
            pps_d = (ph_inc < PH_HIGH);
        end
    end

    assign pps_o      = pps_q;
    assign pps_tick_o = tick_q;
    assign sec_cnt_o  = sec_q;
    assign locked_o   = locked_q;

endmodule
